// File: rtl/merge_pkg.sv
// Shared types and width helpers for the head-merge slot scheduler.
package merge_pkg;

  localparam int REQ_NUM_DEF       = 4;
  localparam int HEAD_NUM_DEF      = 12;
  localparam int HEAD_PER_SLOT_DEF = 4;

  // clog2 clamped to at least 1 so a degenerate count still gets a real bus.
  function automatic int clog2_min1(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return (bits < 1) ? 1 : bits;
  endfunction

  localparam int COUNT_MAX = HEAD_NUM_DEF / HEAD_PER_SLOT_DEF;
  localparam int TAG_WIDTH = clog2_min1(COUNT_MAX);
  localparam int SEL_WIDTH = clog2_min1(REQ_NUM_DEF);

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } merge_sched_state_t;

endpackage

// File: rtl/merge_tag_match.sv
// Per-lane tag compare against the current slot, fixed priority (lane 0 highest).
module merge_tag_match
  import merge_pkg::*;
#(
  parameter int REQ_NUM   = 4,
  parameter int TAG_WIDTH = 2,
  parameter int SEL_WIDTH = 2
) (
  input  logic [REQ_NUM-1:0]           req_valid_n,
  input  logic [REQ_NUM*TAG_WIDTH-1:0] req_tag,
  input  logic [TAG_WIDTH-1:0]         slot_cnt,
  output logic                         hit,
  output logic [SEL_WIDTH-1:0]         win_idx
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    win_idx = '0;
    // Scan high to low so the lowest matching lane is the last write and wins.
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (!req_valid_n[i] && (req_tag[i*TAG_WIDTH +: TAG_WIDTH] == slot_cnt)) begin
        hit     = 1'b1;
        win_idx = SEL_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/merge_slot_sched.sv
// Grants producer slices in strict slot order and hands the merged matrix downstream.
// Optional sticky tag checker: define MERGE_SCHED_ERR_CHK_EN.
module merge_slot_sched
  import merge_pkg::*;
#(
  parameter int REQ_NUM       = 4,
  parameter int HEAD_NUM      = 12,
  parameter int HEAD_PER_SLOT = 4,
  parameter int TAG_WIDTH     = clog2_min1(HEAD_NUM / HEAD_PER_SLOT),
  parameter int SEL_WIDTH     = clog2_min1(REQ_NUM)
) (
  input  logic                         clk_p,
  input  logic                         rst_n,
  input  logic [REQ_NUM-1:0]           req_valid_n,
  input  logic [REQ_NUM*TAG_WIDTH-1:0] req_tag,
  output logic [REQ_NUM-1:0]           grant,
  output logic                         wr_en,
  output logic [SEL_WIDTH-1:0]         wr_sel,
  output logic [TAG_WIDTH-1:0]         wr_slot,
  output logic                         merge_valid_n,
  input  logic                         out_ready,
  output logic                         err
);

  // HEAD_NUM is expected to be an exact multiple of HEAD_PER_SLOT.
  localparam int SLOTS = HEAD_NUM / HEAD_PER_SLOT;

  merge_sched_state_t   state;
  logic [TAG_WIDTH-1:0] slot_cnt;
  logic                 hit;
  logic [SEL_WIDTH-1:0] win_idx;

  merge_tag_match #(
    .REQ_NUM  (REQ_NUM),
    .TAG_WIDTH(TAG_WIDTH),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_match (
    .req_valid_n(req_valid_n),
    .req_tag    (req_tag),
    .slot_cnt   (slot_cnt),
    .hit        (hit),
    .win_idx    (win_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state         <= COLLECT;
      slot_cnt      <= '0;
      grant         <= '0;
      wr_en         <= 1'b0;
      wr_sel        <= '0;
      wr_slot       <= '0;
      merge_valid_n <= 1'b1;
    end else begin
      grant <= '0;
      wr_en <= 1'b0;
      case (state)
        COLLECT: begin
          if (hit) begin
            grant   <= REQ_NUM'(1) << win_idx;
            wr_en   <= 1'b1;
            wr_sel  <= win_idx;
            wr_slot <= slot_cnt;
            if (slot_cnt == TAG_WIDTH'(SLOTS - 1)) begin
              // Last slice: matrix is complete in the same cycle as its write.
              state         <= DONE;
              slot_cnt      <= '0;
              merge_valid_n <= 1'b0;
            end else begin
              slot_cnt <= slot_cnt + TAG_WIDTH'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state         <= COLLECT;
            merge_valid_n <= 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef MERGE_SCHED_ERR_CHK_EN
  logic err_hit;

  // Flags tags that can never be granted or whose slot was already written.
  always_comb begin
    err_hit = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!req_valid_n[i]) begin
        if (int'(req_tag[i*TAG_WIDTH +: TAG_WIDTH]) >= SLOTS) err_hit = 1'b1;
        if ((state == COLLECT) && (req_tag[i*TAG_WIDTH +: TAG_WIDTH] < slot_cnt)) err_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (err_hit) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_merge_slot_sched.sv
// Randomized and directed bench for merge_slot_sched against a slot-order reference model.
module tb_merge_slot_sched;

  localparam int REQ = 4;
  localparam int TW  = 2;
  localparam int SW  = 2;
  localparam int CM  = 3;
`ifdef MERGE_SCHED_ERR_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [10:0] RST_V = 11'b0000_0_00_00_1_0;

  logic              clk_p = 1'b0;
  logic              rst_n;
  logic [REQ-1:0]    req_valid_n;
  logic [REQ*TW-1:0] req_tag;
  logic [REQ-1:0]    grant;
  logic              wr_en;
  logic [SW-1:0]     wr_sel;
  logic [TW-1:0]     wr_slot;
  logic              merge_valid_n;
  logic              out_ready;
  logic              err;

  merge_slot_sched dut (
    .clk_p        (clk_p),
    .rst_n        (rst_n),
    .req_valid_n  (req_valid_n),
    .req_tag      (req_tag),
    .grant        (grant),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_slot      (wr_slot),
    .merge_valid_n(merge_valid_n),
    .out_ready    (out_ready),
    .err          (err)
  );

  always #5 clk_p = ~clk_p;

  // Producer lanes as the bench sees them.
  bit lane_on  [REQ];
  int lane_tag [REQ];

  always_comb begin
    req_valid_n = '1;
    req_tag     = '0;
    for (int i = 0; i < REQ; i++) begin
      req_valid_n[i]         = ~lane_on[i];
      req_tag[i*TW +: TW]    = TW'(lane_tag[i]);
    end
  end

  // Reference model: next slot to fill, round-complete flag, sticky error.
  int       m_next;
  bit       m_done;
  bit       m_err;
  int       exp_grant, exp_sel, exp_slot;
  bit       exp_wr;
  int       n_tests = 0;
  int       n_fail  = 0;

  logic [10:0] obs, exp_v, msk;
  assign obs   = {grant, wr_en, wr_sel, wr_slot, merge_valid_n, err};
  assign exp_v = {4'(exp_grant), exp_wr, 2'(exp_sel), 2'(exp_slot), ~m_done, m_err};
  // Write index/slot are only meaningful alongside a write strobe.
  assign msk   = exp_wr ? 11'h7FF : 11'b1111_1_00_00_1_1;

  task automatic model_reset();
    m_next = 0; m_done = 0; m_err = 0;
    exp_grant = 0; exp_wr = 0; exp_sel = 0; exp_slot = 0;
  endtask

  // Predict the next edge from the inputs now on the pins, then advance one cycle.
  task automatic cycle();
    int w;
    bit e;
    w = -1; e = 0;
    exp_grant = 0; exp_wr = 0; exp_sel = 0; exp_slot = 0;
    for (int i = 0; i < REQ; i++) begin
      if (lane_on[i]) begin
        if (lane_tag[i] >= CM) e = 1;
        if (!m_done && lane_tag[i] < m_next) e = 1;
        if (!m_done && w < 0 && lane_tag[i] == m_next) w = i;
      end
    end
    if (m_done) begin
      if (out_ready) m_done = 0;
    end else if (w >= 0) begin
      exp_grant = 1 << w;
      exp_wr    = 1;
      exp_sel   = w;
      exp_slot  = m_next;
      m_next++;
      if (m_next == CM) begin
        m_next = 0;
        m_done = 1;
      end
    end
    m_err = m_err | (ERR_EN && e);
    @(posedge clk_p);
    #1;
  endtask

  task automatic lanes_off();
    for (int i = 0; i < REQ; i++) begin
      lane_on[i]  = 0;
      lane_tag[i] = 0;
    end
  endtask

  // Drive lane 0 through the remaining slots and let the consumer take the matrix.
  task automatic finish_round();
    lanes_off();
    for (int k = 0; k < CM + 2; k++) begin
      if (m_done) begin
        out_ready = 1;
        cycle();
        out_ready = 0;
        break;
      end
      lane_on[0]  = 1;
      lane_tag[0] = m_next;
      cycle();
      lane_on[0]  = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; out_ready = 0;
    lanes_off();
    model_reset();
    #12;
    n_tests++;
    if (obs !== RST_V) begin
      n_fail++;
      $display("FAIL reset_values got=%b want=%b", obs, RST_V);
    end
    @(negedge clk_p);
    rst_n = 1;
    cycle();
    n_tests++;
    if (obs !== RST_V) begin
      n_fail++;
      $display("FAIL idle_after_reset got=%b want=%b", obs, RST_V);
    end
  endtask

  task automatic test_sequence();
    for (int s = 0; s < CM; s++) begin
      lane_on[0]  = 1;
      lane_tag[0] = s;
      cycle();
      lane_on[0]  = 0;
      n_tests++;
      if (grant !== 4'b0001 || wr_en !== 1'b1 || wr_slot !== TW'(s) || wr_sel !== 2'd0
          || merge_valid_n !== (s != CM - 1)) begin
        n_fail++;
        $display("FAIL seq_slot%0d got=%b want grant=0001 slot=%0d mvn=%0d", s, obs, s, s != CM - 1);
      end
    end
    finish_round();
    n_tests++;
    if (merge_valid_n !== 1'b1 || grant !== 4'b0) begin
      n_fail++;
      $display("FAIL seq_release got=%b want mvn=1 grant=0", obs);
    end
  endtask

  task automatic test_priority();
    lane_on[2] = 1; lane_tag[2] = 1;
    lane_on[1] = 1; lane_tag[1] = 0;
    cycle();
    lane_on[1] = 0;
    n_tests++;
    if (grant !== 4'b0010 || wr_slot !== 2'd0 || wr_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL prio_first got=%b want grant=0010 slot=0 sel=1", obs);
    end
    cycle();
    lane_on[2] = 0;
    n_tests++;
    if (grant !== 4'b0100 || wr_slot !== 2'd1 || wr_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL prio_second got=%b want grant=0100 slot=1 sel=2", obs);
    end
    finish_round();
  endtask

  task automatic test_same_tag();
    lane_on[0] = 1; lane_tag[0] = 0;
    lane_on[3] = 1; lane_tag[3] = 0;
    cycle();
    lane_on[0] = 0;
    n_tests++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL same_tag_win got=%b want=0001", grant);
    end
    cycle();
    n_tests++;
    if (grant !== 4'b0000 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL same_tag_stall got=%b want grant=0000", obs);
    end
    lane_tag[3] = 1;
    cycle();
    lane_on[3] = 0;
    n_tests++;
    if (grant !== 4'b1000 || wr_slot !== 2'd1 || wr_sel !== 2'd3) begin
      n_fail++;
      $display("FAIL same_tag_late got=%b want grant=1000 slot=1", obs);
    end
    finish_round();
  endtask

  task automatic test_done_hold();
    for (int s = 0; s < CM; s++) begin
      lane_on[0] = 1; lane_tag[0] = s;
      cycle();
      lane_on[0] = 0;
    end
    lane_on[1] = 1; lane_tag[1] = 0;
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_tests++;
      if (merge_valid_n !== 1'b0 || grant !== 4'b0 || (obs & msk) !== (exp_v & msk)) begin
        n_fail++;
        $display("FAIL done_hold%0d got=%b want mvn=0 grant=0", k, obs);
      end
    end
    out_ready = 1;
    cycle();
    out_ready = 0;
    n_tests++;
    if (merge_valid_n !== 1'b1 || grant !== 4'b0) begin
      n_fail++;
      $display("FAIL done_release got=%b want mvn=1 grant=0", obs);
    end
    cycle();
    lane_on[1] = 0;
    n_tests++;
    if (grant !== 4'b0010 || wr_slot !== 2'd0) begin
      n_fail++;
      $display("FAIL done_next_round got=%b want grant=0010 slot=0", obs);
    end
    finish_round();
  endtask

  task automatic test_mid_reset();
    for (int s = 0; s < 2; s++) begin
      lane_on[0] = 1; lane_tag[0] = s;
      cycle();
      lane_on[0] = 0;
    end
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_tests++;
    if (obs !== RST_V) begin
      n_fail++;
      $display("FAIL mid_reset_async got=%b want=%b", obs, RST_V);
    end
    @(negedge clk_p);
    rst_n = 1;
    lane_on[0] = 1; lane_tag[0] = 1;
    cycle();
    n_tests++;
    if (grant !== 4'b0 || (obs & msk) !== (exp_v & msk)) begin
      n_fail++;
      $display("FAIL mid_reset_slot1 got=%b want grant=0", obs);
    end
    lane_tag[0] = 0;
    cycle();
    lane_on[0] = 0;
    n_tests++;
    if (grant !== 4'b0001 || wr_slot !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset_restart got=%b want grant=0001 slot=0", obs);
    end
    finish_round();
  endtask

  task automatic test_err();
    lane_on[2] = 1; lane_tag[2] = 3;
    cycle();
    lane_on[2] = 0;
    n_tests++;
    if (err !== ERR_EN || grant !== 4'b0) begin
      n_fail++;
      $display("FAIL err_set got err=%b grant=%b want err=%b grant=0000", err, grant, ERR_EN);
    end
    for (int k = 0; k < 3; k++) cycle();
    n_tests++;
    if (err !== ERR_EN) begin
      n_fail++;
      $display("FAIL err_sticky got=%b want=%b", err, ERR_EN);
    end
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_reset got=%b want=0", err);
    end
    @(negedge clk_p);
    rst_n = 1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < REQ; i++) begin
        if (lane_on[i] && grant[i]) lane_on[i] = 0;
        else if (lane_on[i] && ($urandom % 6 == 0)) lane_on[i] = 0;
        else if (!lane_on[i] && ($urandom % 2 == 0)) begin
          lane_on[i]  = 1;
          lane_tag[i] = int'($urandom % CM);
        end
      end
      out_ready = ($urandom % 3 == 0);
      cycle();
      n_tests++;
      if ((obs & msk) !== (exp_v & msk)) begin
        n_fail++;
        $display("FAIL random_c%0d got=%b want=%b", c, obs, exp_v);
      end
    end
    out_ready = 0;
    lanes_off();
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_priority();
    test_same_tag();
    test_done_hold();
    test_mid_reset();
    test_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/merge_slot_sched.md
# merge_slot_sched

Scheduler in front of the head-merge datapath. It collects per-head-group result slices from `REQ_NUM` producer lanes and grants them strictly in slot order 0..`COUNT_MAX`-1. It drives the datapath's write enable, source select and slot index. It signals a completed merged matrix to the downstream consumer and holds it until the consumer accepts it.

## Interface
Parameters:
- `REQ_NUM`, 4: number of producer lanes.
- `HEAD_NUM`, 12: total attention heads.
- `HEAD_PER_SLOT`, 4: heads per slice. `COUNT_MAX = HEAD_NUM/HEAD_PER_SLOT` is the number of slots, 3 by default. `HEAD_NUM` must be an exact multiple of `HEAD_PER_SLOT`.
- `TAG_WIDTH`, 2: slot-tag width, equal to max(1, clog2(`COUNT_MAX`)).

Ports:
- `clk_p` in, 1: clock.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `req_valid_n` in, `REQ_NUM`: per-lane request, active-low.
- `req_tag` in, `REQ_NUM*TAG_WIDTH`: per-lane slot tag. Lane i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- `grant` out, `REQ_NUM`: one-hot grant pulse, one cycle wide.
- `wr_en` out, 1: datapath slot write strobe.
- `wr_sel` out, clog2(`REQ_NUM`): lane whose data the datapath captures.
- `wr_slot` out, `TAG_WIDTH`: slot index written.
- `merge_valid_n` out, 1: merged matrix complete, active-low.
- `out_ready` in, 1: consumer accepts the merged matrix, active-high.
- `err` out, 1: sticky tag-error flag. Present only with the macro (see Configuration).

## Operation
- Two-state FSM, COLLECT and DONE. Reset state is COLLECT with `slot_cnt`=0.
- In COLLECT, a lane is eligible when its `req_valid_n`=0 and its `req_tag`==`slot_cnt`.
  - Among eligible lanes, the lowest index wins (fixed priority).
  - Non-matching requests stall. They are never dropped or reordered.
- On a win, the next edge registers:
  - `grant[i]`=1, `wr_en`=1, `wr_sel`=i, `wr_slot`=`slot_cnt`;
  - `slot_cnt`+1.
  - If `slot_cnt` was `COUNT_MAX`-1, the FSM goes to DONE and `slot_cnt` wraps to 0.
- In DONE:
  - `merge_valid_n`=0 is held.
  - Requests are ignored; no grant is issued.
  - On `out_ready`=1 the FSM returns to COLLECT next cycle and `merge_valid_n` returns to 1.
- A lane must drop `req_valid_n` in the cycle it sees `grant`. A re-assert with the same tag is not granted again within the round, because `slot_cnt` has already advanced.

## Timing
- Reset values:
  - `grant`=0, `wr_en`=0, `wr_sel`=0, `wr_slot`=0;
  - `merge_valid_n`=1, `err`=0;
  - state=COLLECT, `slot_cnt`=0.
- Grant latency: 1 cycle from a sampled eligible request.
- Throughput: maximum one slot per cycle; back-to-back grants are legal.
- `merge_valid_n` falls in the same cycle as the last `wr_en`.
- The earliest grant of a new round is 1 cycle after the cycle where `out_ready`=1 is sampled.
  - `out_ready` together with a tag-0 request in DONE does not grant in that cycle; the request is granted one cycle later.
- Reset mid-round: the partial round is discarded and all outputs return to reset values immediately (asynchronous).
- `out_ready` sampled in COLLECT has no effect.

## Configuration
- `MERGE_SCHED_ERR_CHK_EN` defined:
  - `err` is set when any lane requests with `req_tag` >= `COUNT_MAX`.
  - `err` is set when any lane requests a tag < `slot_cnt` in COLLECT (slot already written this round).
  - `err` is sticky and cleared only by reset. Scheduling is unaffected.
- Macro undefined: the `err` port is tied 0 and no checker logic is built. Out-of-range tags are never granted and stall silently.

## Structure
- Package `merge_pkg`:
  - `COUNT_MAX` and `TAG_WIDTH` derivation;
  - state enum `merge_sched_state_t` {COLLECT, DONE};
  - `SEL_WIDTH`=clog2(`REQ_NUM`).
- Sub-module `merge_tag_match`: combinational per-lane tag compare plus fixed-priority pick. It outputs a hit flag and the winning index.

## Test plan
- Lane 0 requests tags 0, 1, 2 in sequence → grants at cycles +1, +2, +3 with `wr_slot`=0, 1, 2; `merge_valid_n`=0 with the third grant.
- Lane 2 requests tag 1 and lane 1 requests tag 0 simultaneously → lane 1 is granted first, then lane 2 on the next cycle.
- Lanes 0 and 3 both request tag 0 → `grant`=4'b0001; lane 3 stalls until the next round or until its tag matches.
- Round complete with `out_ready`=0 for 5 cycles → `merge_valid_n` held 0 and a tag-0 request is ignored; `out_ready`=1 → the tag-0 request is granted 2 cycles later.
- Assert `rst_n`=0 after slot 1 is written → outputs reset; the next round starts at slot 0.
- With `MERGE_SCHED_ERR_CHK_EN`: tag 3 request at `COUNT_MAX`=3 → `err`=1 and remains 1 until reset; without the macro, `err`=0 throughout.
